// File: rtl/if_defs.sv
// Shared fetch-stage definitions: FSM state encoding, default memory timeout
// and the counter-to-byte-address helper used by the IF stages.
package if_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } if_state_t;

    localparam logic [7:0] IF_TIMEOUT_DEFAULT = 8'd64;

    // Word counter to byte address, 32-bit modulo so the top counter wraps to base.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [9:0] cnt);
        return base + {20'b0, cnt, 2'b00};
    endfunction

endpackage

// File: rtl/if1b_if.sv
// Bundle of the IF1B upstream handshake, instruction-memory bus and downstream
// handshake. master = fetch stage, slave = its environment.
interface if1b_if;

    logic        if1b_valid_in;
    logic [9:0]  if1b_counter_in;
    logic        if1b_ready_out;
    logic        mem_stb;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        if1b_ready_in;
    logic        if1b_valid_out;
    logic [31:0] if1b_pc_out;
    logic [31:0] if1b_instr_out;
    logic        if1b_timeout_out;

    modport master (
        input  if1b_valid_in, if1b_counter_in, mem_ack, mem_data, if1b_ready_in,
        output if1b_ready_out, mem_stb, mem_addr, if1b_valid_out, if1b_pc_out,
               if1b_instr_out, if1b_timeout_out
    );

    modport slave (
        output if1b_valid_in, if1b_counter_in, mem_ack, mem_data, if1b_ready_in,
        input  if1b_ready_out, mem_stb, mem_addr, if1b_valid_out, if1b_pc_out,
               if1b_instr_out, if1b_timeout_out
    );

endinterface

// File: rtl/if1b_wdog.sv
// Memory-ack watchdog for IF1B: counts REQ cycles without ack and flags expiry
// in the cycle the count would reach TIMEOUT (an ack in that cycle wins).
module if1b_wdog #(
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    input  logic ack,
    output logic expired
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt_q <= 8'd0;
        end else if (run && !ack) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign expired = run && !ack && (cnt_q == TIMEOUT - 8'd1);

endmodule

// File: rtl/if1b.sv
// IF1B fetch stage: turns an upstream word counter into one instruction-memory
// read and presents {pc, instr} downstream. Optional ack timeout: IF1B_TIMEOUT_EN.
module if1b
    import if_defs::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT   = IF_TIMEOUT_DEFAULT
) (
    input logic   clk,
    input logic   rst,
    if1b_if.master bus
);

    if_state_t   state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        stb_q;
    logic        vld_q;
    logic        expired;

    assign bus.if1b_ready_out = (state_q == IDLE) || ((state_q == FULL) && bus.if1b_ready_in);
    assign bus.mem_stb        = stb_q;
    assign bus.mem_addr       = pc_q;
    assign bus.if1b_valid_out = vld_q;
    assign bus.if1b_pc_out    = pc_q;
    assign bus.if1b_instr_out = instr_q;

`ifdef IF1B_TIMEOUT_EN
    logic timeout_q;
    logic start;

    // The counter restarts on every accepted request, whichever state it came from.
    assign start = bus.if1b_valid_in && bus.if1b_ready_out;

    if1b_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .run     (state_q == REQ),
        .ack     (bus.mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.if1b_timeout_out = timeout_q;
`else
    assign expired              = 1'b0;
    assign bus.if1b_timeout_out = 1'b0;
`endif

    // NOTE: pc_q/instr_q are data registers qualified by valid, so they are left out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.if1b_valid_in) begin
                        pc_q    <= word_addr(ADDR_BASE, bus.if1b_counter_in);
                        state_q <= REQ;
                        stb_q   <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        instr_q <= bus.mem_data;
                        state_q <= FULL;
                        stb_q   <= 1'b0;
                        vld_q   <= 1'b1;
                    end else if (expired) begin
                        instr_q <= 32'h0000_0000;
                        state_q <= FULL;
                        stb_q   <= 1'b0;
                        vld_q   <= 1'b1;
                    end
                end
                FULL: begin
                    if (bus.if1b_ready_in) begin
                        vld_q <= 1'b0;
                        if (bus.if1b_valid_in) begin
                            pc_q    <= word_addr(ADDR_BASE, bus.if1b_counter_in);
                            state_q <= REQ;
                            stb_q   <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    stb_q   <= 1'b0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if1b.sv
// Self-checking bench for if1b: two instances (ADDR_BASE 0 and 32'h1000) share
// one stimulus; address vectors, hand-written corner cases, then random traffic.
module tb_if1b;

    localparam logic [31:0] BASE1 = 32'h0000_1000;
    localparam int          TO    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [9:0]  counter_in = '0;
    logic        ready_in = 1'b1;
    logic        ack = 1'b0;
    logic [31:0] data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    if1b_if b0 ();
    if1b_if b1 ();

    assign b0.if1b_valid_in   = valid_in;
    assign b0.if1b_counter_in = counter_in;
    assign b0.if1b_ready_in   = ready_in;
    assign b0.mem_ack         = ack;
    assign b0.mem_data        = data;
    assign b1.if1b_valid_in   = valid_in;
    assign b1.if1b_counter_in = counter_in;
    assign b1.if1b_ready_in   = ready_in;
    assign b1.mem_ack         = ack;
    assign b1.mem_data        = data;

    if1b #(.ADDR_BASE(32'h0), .TIMEOUT(8'(TO))) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
    if1b #(.ADDR_BASE(BASE1), .TIMEOUT(8'(TO))) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_in = 1'b0; ack = 1'b0; ready_in = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        settle();
    endtask

    typedef struct {
        logic [9:0]  cnt;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[5];

    // Reference model state: outstanding request / held result, as flags plus payload.
    bit          m_req, m_full, m_to;
    logic [9:0]  m_cnt;
    logic [31:0] m_instr;
    int          m_wait;

    initial begin
        vecs[0] = '{10'd5,    32'h0000_0014, 32'h0000_1014, 32'hDEAD_BEEF};
        vecs[1] = '{10'd1023, 32'h0000_0FFC, 32'h0000_1FFC, 32'hCAFE_0001};
        vecs[2] = '{10'd0,    32'h0000_0000, 32'h0000_1000, 32'h1234_5678};
        vecs[3] = '{10'd512,  32'h0000_0800, 32'h0000_1800, 32'h0BAD_F00D};
        vecs[4] = '{10'd1,    32'h0000_0004, 32'h0000_1004, 32'hFFFF_FFFF};

        // Reset state after three reset cycles with no input activity.
        do_reset();
        check("rst_valid_out", 32'(b0.if1b_valid_out), 32'd0);
        check("rst_mem_stb",   32'(b0.mem_stb), 32'd0);
        check("rst_ready_out", 32'(b0.if1b_ready_out), 32'd1);
        check("rst_timeout",   32'(b0.if1b_timeout_out), 32'd0);

        // Address mapping and minimum latency, one transaction per vector.
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1; counter_in = vecs[i].cnt; ack = 1'b0;
            tick();
            valid_in = 1'b0; ack = 1'b1; data = vecs[i].data;
            settle();
            check("vec_stb",        32'(b0.mem_stb), 32'd1);
            check("vec_addr0",      b0.mem_addr, vecs[i].addr0);
            check("vec_addr1",      b1.mem_addr, vecs[i].addr1);
            check("vec_valid_early", 32'(b0.if1b_valid_out), 32'd0);
            tick();
            ack = 1'b0;
            settle();
            check("vec_valid",  32'(b0.if1b_valid_out), 32'd1);
            check("vec_pc0",    b0.if1b_pc_out, vecs[i].addr0);
            check("vec_pc1",    b1.if1b_pc_out, vecs[i].addr1);
            check("vec_instr",  b0.if1b_instr_out, vecs[i].data);
            check("vec_stb_off", 32'(b0.mem_stb), 32'd0);
            tick();
            check("vec_drained", 32'(b0.if1b_valid_out), 32'd0);
        end

        // Downstream stall while upstream keeps offering a new counter.
        ready_in = 1'b0; valid_in = 1'b1; counter_in = 10'd7;
        tick();
        counter_in = 10'd9; ack = 1'b1; data = 32'hA5A5_0007;
        tick();
        ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("stall_valid", 32'(b0.if1b_valid_out), 32'd1);
            check("stall_pc",    b0.if1b_pc_out, 32'h0000_001C);
            check("stall_instr", b0.if1b_instr_out, 32'hA5A5_0007);
            check("stall_ready", 32'(b0.if1b_ready_out), 32'd0);
            check("stall_stb",   32'(b0.mem_stb), 32'd0);
            tick();
        end
        ready_in = 1'b1;
        settle();
        check("stall_release_ready", 32'(b0.if1b_ready_out), 32'd1);
        tick();
        valid_in = 1'b0;
        settle();
        check("b2b_stb",   32'(b0.mem_stb), 32'd1);
        check("b2b_addr",  b0.mem_addr, 32'h0000_0024);
        check("b2b_valid", 32'(b0.if1b_valid_out), 32'd0);
        ack = 1'b1; data = 32'h0000_0009;
        tick();
        ack = 1'b0;
        settle();
        check("b2b_pc", b0.if1b_pc_out, 32'h0000_0024);
        tick();

        // Reset during REQ, with ack coincident with and after the reset cycle.
        valid_in = 1'b1; counter_in = 10'd3;
        tick();
        valid_in = 1'b0; rst = 1'b1; ack = 1'b1; data = 32'h5555_AAAA;
        settle();
        check("rreq_stb_before", 32'(b0.mem_stb), 32'd1);
        tick();
        rst = 1'b0;
        settle();
        check("rreq_stb",   32'(b0.mem_stb), 32'd0);
        check("rreq_valid", 32'(b0.if1b_valid_out), 32'd0);
        check("rreq_ready", 32'(b0.if1b_ready_out), 32'd1);
        tick();
        ack = 1'b0;
        check("rreq_valid_after", 32'(b0.if1b_valid_out), 32'd0);
        check("rreq_stb_after",   32'(b0.mem_stb), 32'd0);

`ifdef IF1B_TIMEOUT_EN
        // No ack: request held TIMEOUT cycles, then a zero instruction and a sticky flag.
        ready_in = 1'b0; valid_in = 1'b1; counter_in = 10'd2;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < TO; i++) begin
            check("to_stb_held", 32'(b0.mem_stb), 32'd1);
            tick();
        end
        check("to_stb_drop", 32'(b0.mem_stb), 32'd0);
        check("to_valid",    32'(b0.if1b_valid_out), 32'd1);
        check("to_instr",    b0.if1b_instr_out, 32'h0);
        check("to_flag",     32'(b0.if1b_timeout_out), 32'd1);
        ready_in = 1'b1;
        tick();
        tick();
        check("to_flag_sticky", 32'(b0.if1b_timeout_out), 32'd1);
        do_reset();
        check("to_flag_cleared", 32'(b0.if1b_timeout_out), 32'd0);
`endif

        // Random traffic against the transaction-level model.
        do_reset();
        m_req = 0; m_full = 0; m_to = 0; m_wait = 0;
        m_cnt = '0; m_instr = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit exp_ready;
            valid_in   = ($urandom_range(0, 2) != 0);
            counter_in = 10'($urandom);
            ready_in   = ($urandom_range(0, 3) != 0);
            ack        = ($urandom_range(0, 2) != 0);
            data       = $urandom;
            settle();
            exp_ready = !m_req && (!m_full || ready_in);
            check("rnd_ready", 32'(b0.if1b_ready_out), 32'(exp_ready));
            check("rnd_stb",   32'(b0.mem_stb), 32'(m_req));
            check("rnd_valid", 32'(b0.if1b_valid_out), 32'(m_full));
            check("rnd_to",    32'(b0.if1b_timeout_out), 32'(m_to));
            if (m_req) begin
                check("rnd_addr0", b0.mem_addr, 32'h0 + {20'b0, m_cnt, 2'b00});
                check("rnd_addr1", b1.mem_addr, BASE1 + {20'b0, m_cnt, 2'b00});
            end
            if (m_full) begin
                check("rnd_pc1",   b1.if1b_pc_out, BASE1 + {20'b0, m_cnt, 2'b00});
                check("rnd_instr", b0.if1b_instr_out, m_instr);
            end
            // Model update for this clock edge.
            if (m_req) begin
                if (ack) begin
                    m_req = 0; m_full = 1; m_instr = data;
                end else begin
                    m_wait++;
`ifdef IF1B_TIMEOUT_EN
                    if (m_wait == TO) begin
                        m_req = 0; m_full = 1; m_instr = 32'h0; m_to = 1;
                    end
`endif
                end
            end else if (m_full && ready_in) begin
                m_full = 0;
            end
            if (valid_in && exp_ready) begin
                m_req = 1; m_cnt = counter_in; m_wait = 0;
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if1b.md
IF1B -- requirements
Module: if1b

Interface
REQ-001 Parameter ADDR_BASE, default 32'h0000_0000: byte address of fetch window start.
REQ-002 Parameter TIMEOUT, default 8'd64: max cycles waiting for mem_ack (used only with IF1B_TIMEOUT_EN).
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if1b_valid_in  input  1  upstream counter valid.
REQ-006 if1b_counter_in  input  10  upstream word counter; meaningful only when valid.
REQ-007 if1b_ready_out  output  1  to upstream; transfer when valid_in & ready_out high at posedge.
REQ-008 mem_stb  output  1  instruction memory read request.
REQ-009 mem_addr  output  32  byte address of request.
REQ-010 mem_ack  input  1  read data valid / request done.
REQ-011 mem_data  input  32  instruction word.
REQ-012 if1b_ready_in  input  1  downstream ready.
REQ-013 if1b_valid_out  output  1  fetched instruction valid.
REQ-014 if1b_pc_out  output  32  address of fetched instruction.
REQ-015 if1b_instr_out  output  32  fetched instruction.
REQ-016 if1b_timeout_out  output  1  sticky memory-timeout flag.

Function
REQ-017 FSM states IDLE, REQ, FULL.
REQ-018 Address: pc = ADDR_BASE + {counter, 2'b00}, 32-bit modulo; counter 1023 -> 0 wrap maps back to ADDR_BASE.
REQ-019 if1b_ready_out combinational = (IDLE) | (FULL & if1b_ready_in); never depends on mem_ack.
REQ-020 IDLE & valid_in: register pc, next state REQ; else stay IDLE.
REQ-021 REQ: mem_stb = 1, mem_addr = registered pc, both stable until ack; mem_stb = 0 in all other states.
REQ-022 REQ & mem_ack: capture mem_data into instr register, next state FULL; minimum latency accept->valid_out = 2 cycles (ack in first REQ cycle).
REQ-023 FULL: if1b_valid_out = 1; pc/instr outputs held stable until transfer.
REQ-024 FULL & ready_in & valid_in: register new pc, next REQ (back-to-back, no bubble on input side).
REQ-025 FULL & ready_in & ~valid_in: next IDLE.
REQ-026 FULL & ~ready_in: hold all state; upstream stalled via ready_out = 0.
REQ-027 mem_ack outside REQ: ignored, no state change.
REQ-028 if1b_pc_out / if1b_instr_out unspecified (x permitted) while valid_out = 0.

Reset
REQ-029 rst: state IDLE, if1b_valid_out 0, mem_stb 0, if1b_timeout_out 0, timeout counter 0.
REQ-030 rst during REQ: mem_stb 0 the following cycle; ack coincident with or after rst ignored.
REQ-031 rst overrides all other inputs in the same cycle.

Configuration
REQ-032 Macro IF1B_TIMEOUT_EN defined: 8-bit counter cleared on REQ entry, increments each REQ cycle without ack.
REQ-033 Counter reaching TIMEOUT: drop mem_stb, load instr 32'h0000_0000, go FULL, set if1b_timeout_out until rst.
REQ-034 Ack in the same cycle the counter reaches TIMEOUT: ack wins, no timeout.
REQ-035 Macro undefined: no counter logic; if1b_timeout_out tied 0; REQ waits indefinitely.

Structure
REQ-036 State encodings (IDLE=2'd0, REQ=2'd1, FULL=2'd2) and default TIMEOUT in shared fetch-stage package if_defs, shared with other IF stages.
REQ-037 Timeout counter in sub-module if1b_wdog (inputs clk, rst, start, run, ack; output expired), instantiated only under IF1B_TIMEOUT_EN.

Verification
REQ-038 rst 3 cycles, valid_in=0 -> valid_out=0, mem_stb=0, ready_out=1, timeout_out=0.
REQ-039 ADDR_BASE=0, counter=5, ack on first REQ cycle, data=32'hDEAD_BEEF, ready_in=1 -> mem_addr=32'h14; valid_out 2 cycles after accept with pc 32'h14, instr 32'hDEAD_BEEF.
REQ-040 Counters 1023 then 0, ADDR_BASE=32'h1000 -> mem_addr 32'h1FFC then 32'h1000.
REQ-041 ready_in=0 for 4 cycles in FULL, valid_in=1 -> outputs stable, ready_out=0, no second mem_stb; ready_in=1 -> next REQ next cycle.
REQ-042 Macro on, TIMEOUT=8, no ack -> mem_stb high 8 cycles, then valid_out=1, instr=0, timeout_out=1 until rst.
REQ-043 rst asserted during REQ with ack next cycle -> mem_stb=0, valid_out stays 0, state IDLE.
